// File: rtl/rom_rd_pkg.sv
// Shared types and constants for the ROM read responder.
// The FSM state enum, the ROM word-index width and the default DDRAM base
// address of the ROM image live here.
package rom_rd_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } rom_rd_state_e;

  // Width of a 64-bit word index into the ROM (byte address bits [27:3])
  localparam int ROM_WORD_W = 25;

  // Default 64-bit-word DDRAM base of the ROM image
  localparam logic [28:0] ROM_BASE_ADDR = 29'h0300000;

  // DDRAM word address of a ROM word; the carry out of bit 28 is discarded
  function automatic logic [28:0] ddr_word_addr(input logic [28:0] base,
                                                input logic [ROM_WORD_W-1:0] word);
    return base + {4'b0000, word};
  endfunction

endpackage

// File: rtl/rom_rd_responder.sv
// ROM read responder: turns toggle-style read requests from the core into
// single DDRAM reads of one 64-bit word and returns the data on dout.
//
// Optional feature: define ROM_RD_CACHE_EN to add a one-entry cache that
// remembers the word currently held on dout, so a repeated read of the
// same word completes without touching DDRAM.
//
// Handshake: the core flips rd_req to post a request, with rdaddr stable
// until rd_ack flips to match it; dout is valid whenever rd_ack == rd_req.
// The core must not flip rd_req again while a request is outstanding.
// On the DDRAM side DDRAM_RD is a level request held with a constant
// DDRAM_ADDR until a cycle with DDRAM_BUSY=0 accepts it; returned data is
// qualified by DDRAM_DOUT_READY and only looked at while waiting for it.
module rom_rd_responder
  import rom_rd_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = ROM_BASE_ADDR,
  parameter logic [7:0]  BURST     = 8'd1
) (
  input  logic          clk_sys,
  input  logic          reset_n,

  input  logic          rd_req,
  input  logic [27:0]   rdaddr,
  output logic          rd_ack,
  output logic [63:0]   dout,
  input  logic          inv,

  input  logic          DDRAM_BUSY,
  output logic [28:0]   DDRAM_ADDR,
  output logic          DDRAM_RD,
  output logic [7:0]    DDRAM_BURSTCNT,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_WE,
  output logic [7:0]    DDRAM_BE,
  output logic [63:0]   DDRAM_DIN,

  output rom_rd_state_e dbg_state
);

  rom_rd_state_e          state;
  logic [ROM_WORD_W-1:0]  req_word;
  logic [7:0]             drain_cnt;
  logic                   req_new;
  logic                   cache_hit;
  logic                   load_beat;
  logic [7:0]             extra_beats;

  // A request is outstanding while the two toggle bits disagree
  assign req_new = (rd_req != rd_ack);

  // Only the first returned beat is taken, and only while waiting for it
  assign load_beat = (state == WAIT) && DDRAM_DOUT_READY;

  // Beats that follow the first one in a burst and must be drained
  assign extra_beats = (BURST > 8'd1) ? (BURST - 8'd1) : 8'd0;

  // Read-only responder: write side tied off, burst length is static
  assign DDRAM_WE       = 1'b0;
  assign DDRAM_BE       = 8'hFF;
  assign DDRAM_DIN      = 64'd0;
  assign DDRAM_BURSTCNT = BURST;

  assign dbg_state = state;

`ifdef ROM_RD_CACHE_EN
  logic [ROM_WORD_W-1:0] cache_tag;
  logic                  cache_valid;
  logic                  inv_pend;
  logic                  unused_addr_lsb;

  // inv in the same cycle as a matching request must still force a miss
  assign cache_hit = cache_valid && !inv && (cache_tag == rdaddr[27:3]);

  assign unused_addr_lsb = &{1'b0, rdaddr[2:0]};

  // Cache entry: tag follows every load; an invalidate seen while the
  // transfer is in flight leaves the newly loaded word invalid
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cache_tag   <= '0;
      cache_valid <= 1'b0;
      inv_pend    <= 1'b0;
    end else begin
      if (load_beat) begin
        cache_tag   <= req_word;
        cache_valid <= !(inv || inv_pend);
      end else if (inv) begin
        cache_valid <= 1'b0;
      end

      if (state == IDLE) begin
        inv_pend <= 1'b0;
      end else if (inv) begin
        inv_pend <= 1'b1;
      end
    end
  end
`else
  logic unused_inputs;

  // No cache: every request goes to DDRAM and inv has nothing to clear
  assign cache_hit     = 1'b0;
  assign unused_inputs = &{1'b0, inv, rdaddr[2:0]};
`endif

  // Request FSM with registered DDRAM command, data and acknowledge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_ack     <= 1'b0;
      dout       <= '0;
      DDRAM_RD   <= 1'b0;
      DDRAM_ADDR <= '0;
      req_word   <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_new) begin
            req_word <= rdaddr[27:3];
            if (cache_hit) begin
              state <= DONE;
            end else begin
              DDRAM_RD   <= 1'b1;
              DDRAM_ADDR <= ddr_word_addr(BASE_ADDR, rdaddr[27:3]);
              state      <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // Command stays put until DDRAM takes it
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (DDRAM_DOUT_READY) begin
            dout      <= DDRAM_DOUT;
            drain_cnt <= extra_beats;
            state     <= DONE;
          end
        end

        DONE: begin
          // Swallow the rest of a burst before answering, so its beats
          // can never be mistaken for the data of a later request
          if (drain_cnt == 8'd0) begin
            rd_ack <= ~rd_ack;
            state  <= IDLE;
          end else if (DDRAM_DOUT_READY) begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rd_responder.sv
// Self-checking bench for rom_rd_responder.
// Inputs are driven and outputs sampled on the falling clock edge. A small
// DDRAM model answers reads with a chosen busy stall and latency, and a
// reference model (last data word, one-entry cache) predicts dout, the
// request address, the read count and the acknowledge latency.
module tb_rom_rd_responder;
  import rom_rd_pkg::*;

  localparam logic [28:0] BASE = 29'h0300000;
`ifdef ROM_RD_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  // Clock / reset
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          rd_req = 1'b0;
  logic [27:0]   rdaddr = '0;
  logic          rd_ack;
  logic [63:0]   dout;
  logic          inv = 1'b0;
  logic          DDRAM_BUSY = 1'b0;
  logic [28:0]   DDRAM_ADDR;
  logic          DDRAM_RD;
  logic [7:0]    DDRAM_BURSTCNT;
  logic [63:0]   DDRAM_DOUT = '0;
  logic          DDRAM_DOUT_READY = 1'b0;
  logic          DDRAM_WE;
  logic [7:0]    DDRAM_BE;
  logic [63:0]   DDRAM_DIN;
  rom_rd_state_e dbg_state;

  rom_rd_responder dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .rd_req           (rd_req),
    .rdaddr           (rdaddr),
    .rd_ack           (rd_ack),
    .dout             (dout),
    .inv              (inv),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_DIN        (DDRAM_DIN),
    .dbg_state        (dbg_state)
  );

  // Scoreboard state
  int           n_checks = 0;
  int           n_errors = 0;
  logic [63:0]  exp_q[$];

  // Reference model: word currently on dout and the one-entry cache
  logic [63:0]  m_dout  = '0;
  bit           m_valid = 1'b0;
  logic [24:0]  m_tag   = '0;
  logic [28:0]  last_rd_addr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Idle cycles with stray DDRAM activity that must not disturb anything
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      DDRAM_DOUT_READY = 1'($urandom_range(0, 1));
      DDRAM_DOUT       = {$urandom, $urandom};
      DDRAM_BUSY       = 1'($urandom_range(0, 1));
      step();
      check_eq("idle_dout_hold", dout, m_dout);
      check_eq("idle_no_rd", 64'(DDRAM_RD), 64'd0);
    end
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_BUSY       = 1'b0;
  endtask

  // One request. busy_n: cycles DDRAM stays busy on the command; lat: the
  // data beat arrives lat cycles after the command is accepted; inv_at:
  // loop cycle in which inv is pulsed (0 = with request detection, -1 none).
  task automatic do_req(input logic [27:0] addr, input logic [63:0] data,
                        input int busy_n, input int lat, input int inv_at,
                        input bit do_toggle);
    bit          hit;
    bit          done;
    int          edges, rd_cycles, accepts, acc_edge, busy_left, exp_lat;
    logic [28:0] exp_addr;

    hit      = CACHE_EN && m_valid && (m_tag == addr[27:3]) && (inv_at != 0);
    exp_addr = 29'((32'(BASE) + 32'(addr >> 3)) & 32'h1FFF_FFFF);
    exp_lat  = hit ? 2 : 3 + busy_n + lat;
    exp_q.push_back(hit ? m_dout : data);

    rdaddr = addr;
    if (do_toggle) rd_req = ~rd_req;
    edges = 0; rd_cycles = 0; accepts = 0; acc_edge = -1; busy_left = busy_n; done = 1'b0;

    while (!done && edges < 200) begin
      inv = (edges == inv_at);
      if (DDRAM_RD) begin
        rd_cycles++;
        check_eq("ddr_addr_held", 64'(DDRAM_ADDR), 64'(exp_addr));
        if (busy_left > 0) begin
          DDRAM_BUSY = 1'b1;
          busy_left--;
        end else begin
          DDRAM_BUSY   = 1'b0;
          accepts++;
          acc_edge     = edges + 1;
          last_rd_addr = DDRAM_ADDR;
        end
      end else begin
        DDRAM_BUSY = 1'($urandom_range(0, 1));
      end
      if (acc_edge >= 0 && edges + 1 == acc_edge + lat) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = data;
      end else if (acc_edge >= 0 && edges + 1 < acc_edge + lat) begin
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT       = {$urandom, $urandom};
      end else begin
        DDRAM_DOUT_READY = 1'($urandom_range(0, 1));
        DDRAM_DOUT       = {$urandom, $urandom};
      end
      step();
      edges++;
      if (rd_ack == rd_req) done = 1'b1;
    end
    inv = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_BUSY = 1'b0;

    check_eq("req_done", 64'(done), 64'd1);
    check_eq("ack_latency", 64'(edges), 64'(exp_lat));
    check_eq("rd_cycles", 64'(rd_cycles), hit ? 64'd0 : 64'(busy_n + 1));
    check_eq("rd_accepts", 64'(accepts), hit ? 64'd0 : 64'd1);
    check_eq("dout", dout, exp_q.pop_front());

    if (hit) begin
      if (inv_at > 0 && inv_at < edges) m_valid = 1'b0;
    end else begin
      m_dout  = data;
      m_tag   = addr[27:3];
      m_valid = CACHE_EN && !(inv_at > 0 && inv_at < edges);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rd_ack"}, 64'(rd_ack), 64'd0);
    check_eq({tag, "_dout"}, dout, 64'd0);
    check_eq({tag, "_ddr_rd"}, 64'(DDRAM_RD), 64'd0);
    check_eq({tag, "_ddr_addr"}, 64'(DDRAM_ADDR), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] addr;
    int          pick, r, lat, inv_at;

    // Reset state and static outputs
    @(negedge clk_sys);
    check_reset_state("reset");
    check_eq("ddr_we", 64'(DDRAM_WE), 64'd0);
    check_eq("ddr_be", 64'(DDRAM_BE), 64'hFF);
    check_eq("ddr_din", DDRAM_DIN, 64'd0);
    check_eq("ddr_burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    step();
    reset_n = 1'b1;
    idle_cycles(3);

    // Busy stall: command held for 4 busy cycles plus the accepting one
    do_req(28'h0000200, {$urandom, $urandom}, 4, 2, -1, 1'b1);
    idle_cycles(2);

    // Basic miss with a 5-cycle DDR latency
    do_req(28'h0000108, 64'hDEADBEEF01234567, 0, 5, -1, 1'b1);
    check_eq("miss_ddr_addr", 64'(last_rd_addr), 64'h0300021);
    idle_cycles(2);

    // Same word again: cache hit when enabled, full read otherwise
    do_req(28'h000010C, {$urandom, $urandom}, 0, 3, -1, 1'b1);
    idle_cycles(2);

    // inv together with a matching request forces a reload
    do_req(28'h000010C, {$urandom, $urandom}, 0, 2, 0, 1'b1);
    idle_cycles(1);

    // inv while waiting for data leaves the new word uncached
    do_req(28'h0000300, {$urandom, $urandom}, 1, 4, 3, 1'b1);
    do_req(28'h0000300, {$urandom, $urandom}, 0, 1, -1, 1'b1);
    do_req(28'h0000300, {$urandom, $urandom}, 0, 1, -1, 1'b1);
    idle_cycles(2);

    // Randomized traffic over a few recurring words
    for (int n = 0; n < 30; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0:       addr = 28'h0000108;
        1:       addr = 28'h0000300 | 28'($urandom_range(0, 7));
        2:       addr = 28'hFFFFFF8;
        default: addr = 28'($urandom);
      endcase
      lat    = $urandom_range(1, 5);
      r      = $urandom_range(0, 5);
      inv_at = (r == 0) ? 0 : (r == 1) ? 2 : -1;
      do_req(addr, {$urandom, $urandom}, $urandom_range(0, 3), lat, inv_at, 1'b1);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset while waiting for data, then a stray late beat
    rdaddr = 28'h0000400;
    rd_req = ~rd_req;
    DDRAM_BUSY = 1'b0;
    DDRAM_DOUT_READY = 1'b0;
    repeat (4) step();
    check_eq("pre_reset_state", 64'(dbg_state), 64'(WAIT));
    reset_n = 1'b0;
    #1;
    check_reset_state("wait_reset");
    rd_req = 1'b0;
    step();
    reset_n = 1'b1;
    m_dout = '0; m_valid = 1'b0;
    DDRAM_DOUT_READY = 1'b1;
    DDRAM_DOUT = 64'hBAD0BAD0BAD0BAD0;
    step();
    DDRAM_DOUT_READY = 1'b0;
    check_reset_state("stray_beat");
    do_req(28'h0000400, {$urandom, $urandom}, 1, 2, -1, 1'b1);
    idle_cycles(2);

    // Request already pending when reset is released is serviced as new
    reset_n = 1'b0;
    rd_req  = 1'b1;
    m_dout = '0; m_valid = 1'b0;
    step();
    reset_n = 1'b1;
    do_req(28'h0000108, {$urandom, $urandom}, 0, 2, -1, 1'b0);
    do_req(28'h0000108, {$urandom, $urandom}, 0, 2, -1, 1'b1);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
